// File: rtl/cipu_pkg.sv
// cipu_pkg: shared definitions for the CIPU stream transmitter.
//   - ASCII constants used by the check-in stream protocol
//   - playback FSM state encoding
//   - script entry layout {character, pop count}
package cipu_pkg;

  localparam logic [7:0] CH_SEMI   = 8'h3B;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_Z      = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_POP = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] ch;
    logic [3:0] num;
  } entry_t;

  // Even parity over a script entry, available for storage protection.
  function automatic logic entry_parity(input entry_t e);
    return ^{e.ch, e.num};
  endfunction

endpackage

// File: rtl/cipu_script_mem.sv
// cipu_script_mem: one script store for the CIPU stream transmitter.
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset (clears the write pointer only)
//   wr_en_i   append wr_data_i at the write pointer (dropped when full)
//   wr_data_i entry to append
//   rd_ptr_i  read address (combinational read)
//   rd_data_o entry at rd_ptr_i
//   wr_ptr_o  number of entries stored
//   full_o    write pointer has reached DEPTH
module cipu_script_mem
  import cipu_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  entry_t                     wr_data_i,
  input  logic [$clog2(DEPTH):0]     rd_ptr_i,
  output entry_t                     rd_data_o,
  output logic [$clog2(DEPTH):0]     wr_ptr_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   wr_ptr_d;
  logic            do_wr_s;
  logic            unused_rd_msb_s;

  assign full_o   = (wr_ptr_q >= PW'(DEPTH));
  assign do_wr_s  = wr_en_i && !full_o;
  assign wr_ptr_o = wr_ptr_q;

  // The read pointer's extra bit only marks "past the end"; callers guard on it.
  assign rd_data_o       = mem_q[rd_ptr_i[AW-1:0]];
  assign unused_rd_msb_s = rd_ptr_i[AW];

  // Next write pointer: advance only on an accepted write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Write pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cipu_stream_tx.sv
// cipu_stream_tx: plays a stored passenger script and baggage script into CIPU.
//   load_en/load_sel/load_char/load_num  script loading (IDLE only)
//   start                                begin / replay playback (IDLE or DONE)
//   done_thing, done_lifo                CIPU handshakes for ';' and '$'
//   people_thing_in, ready_fifo          passenger stream, one entry per cycle
//   thing_in, thing_num, ready_lifo      baggage stream, handshake paced
//   busy, tx_done                        playback status
//   load_ovf, timeout_err                sticky error flags
// All outputs are registered; status outputs follow the FSM state by one cycle.
module cipu_stream_tx
  import cipu_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic       load_sel,
  input  logic [7:0] load_char,
  input  logic [3:0] load_num,
  input  logic       start,
  input  logic       done_thing,
  input  logic       done_lifo,
  output logic [7:0] people_thing_in,
  output logic       ready_fifo,
  output logic [7:0] thing_in,
  output logic [3:0] thing_num,
  output logic       ready_lifo,
  output logic       busy,
  output logic       tx_done,
  output logic       load_ovf,
  output logic       timeout_err
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] bptr_q, bptr_d;
  logic [PW-1:0] pptr_q, pptr_d;
  logic          pact_q, pact_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          end_seen_q, end_seen_d;

  logic [7:0]    people_q, people_d;
  logic          ready_fifo_q, ready_fifo_d;
  logic [7:0]    thing_q, thing_d;
  logic [3:0]    num_q, num_d;
  logic          ready_lifo_q, ready_lifo_d;
  logic          busy_q, busy_d;
  logic          tx_done_q, tx_done_d;
  logic          load_ovf_q, load_ovf_d;
  logic          timeout_q, timeout_d;

  entry_t        wr_entry_s;
  entry_t        p_rd_s, b_rd_s;
  logic [PW-1:0] p_wr_ptr_s, b_wr_ptr_s;
  logic          p_full_s, b_full_s;
  logic          load_ok_s, p_wr_en_s, b_wr_en_s, sel_full_s;
  logic          pax_done_s, bag_empty_s, end_ack_s;
  logic          unused_pax_num_s;

  assign load_ok_s  = load_en && (state_q == ST_IDLE);
  assign p_wr_en_s  = load_ok_s && !load_sel;
  assign b_wr_en_s  = load_ok_s && load_sel;
  assign sel_full_s = load_sel ? b_full_s : p_full_s;
  assign wr_entry_s = {load_char, load_num};

  // Passenger entries carry a count field that nothing downstream consumes.
  assign unused_pax_num_s = ^p_rd_s.num;

  // pptr_q counts entries already issued, so equality means the stream is spent.
  assign pax_done_s  = (pptr_q >= p_wr_ptr_s);
  assign bag_empty_s = (bptr_q >= b_wr_ptr_s);
  // done_lifo may arrive before the passengers finish; remember it.
  assign end_ack_s   = done_lifo || end_seen_q;

  cipu_script_mem #(.DEPTH(DEPTH)) u_pax_mem (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (p_wr_en_s),
    .wr_data_i (wr_entry_s),
    .rd_ptr_i  (pptr_q),
    .rd_data_o (p_rd_s),
    .wr_ptr_o  (p_wr_ptr_s),
    .full_o    (p_full_s)
  );

  cipu_script_mem #(.DEPTH(DEPTH)) u_bag_mem (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (b_wr_en_s),
    .wr_data_i (wr_entry_s),
    .rd_ptr_i  (bptr_q),
    .rd_data_o (b_rd_s),
    .wr_ptr_o  (b_wr_ptr_s),
    .full_o    (b_full_s)
  );

  // Next-state logic for the passenger stream, baggage FSM and output registers.
  always_comb begin
    state_d      = state_q;
    bptr_d       = bptr_q;
    pptr_d       = pptr_q;
    pact_d       = pact_q;
    wcnt_d       = wcnt_q;
    end_seen_d   = end_seen_q;
    people_d     = 8'h00;
    ready_fifo_d = 1'b0;
    thing_d      = 8'h00;
    num_d        = 4'h0;
    ready_lifo_d = 1'b0;
    busy_d       = (state_q == ST_SEND) || (state_q == ST_WAIT_POP) ||
                   (state_q == ST_WAIT_END);
    tx_done_d    = (state_q == ST_DONE) && !start;
    load_ovf_d   = load_ovf_q;
    timeout_d    = timeout_q;

    if (load_ok_s && sel_full_s) begin
      load_ovf_d = 1'b1;
    end else begin
      load_ovf_d = load_ovf_q;
    end

    // Passenger stream is free-running once started; the baggage FSM never stalls it.
    if (pact_q) begin
      if (!pax_done_s) begin
        people_d     = p_rd_s.ch;
        ready_fifo_d = 1'b1;
        pptr_d       = pptr_q + PW'(1);
      end else begin
        pact_d = 1'b0;
      end
    end else begin
      pact_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SEND;
          bptr_d     = '0;
          pptr_d     = '0;
          pact_d     = 1'b1;
          end_seen_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_SEND: begin
        ready_lifo_d = 1'b1;
        if (bag_empty_s) begin
          // Script ended without a terminator: supply one.
          thing_d    = CH_DOLLAR;
          state_d    = ST_WAIT_END;
          wcnt_d     = '0;
          end_seen_d = 1'b0;
        end else begin
          thing_d = b_rd_s.ch;
          bptr_d  = bptr_q + PW'(1);
          if (b_rd_s.ch == CH_SEMI) begin
            num_d   = b_rd_s.num;
            state_d = ST_WAIT_POP;
            wcnt_d  = '0;
          end else if (b_rd_s.ch == CH_DOLLAR) begin
            state_d    = ST_WAIT_END;
            wcnt_d     = '0;
            end_seen_d = 1'b0;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_WAIT_POP: begin
        // Handshake is checked first so it beats a simultaneous expiry.
        if (done_thing) begin
          state_d = ST_SEND;
        end else if (wcnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      ST_WAIT_END: begin
        if (done_lifo) begin
          end_seen_d = 1'b1;
        end else begin
          end_seen_d = end_seen_q;
        end
        if (end_ack_s && pax_done_s) begin
          state_d = ST_DONE;
        end else if (end_ack_s) begin
          // Terminator acknowledged; only the passenger tail is outstanding.
          state_d = ST_WAIT_END;
        end else if (wcnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointers and registered outputs; reset clears all but script contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bptr_q       <= '0;
      pptr_q       <= '0;
      pact_q       <= 1'b0;
      wcnt_q       <= '0;
      end_seen_q   <= 1'b0;
      people_q     <= 8'h00;
      ready_fifo_q <= 1'b0;
      thing_q      <= 8'h00;
      num_q        <= 4'h0;
      ready_lifo_q <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      load_ovf_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bptr_q       <= bptr_d;
      pptr_q       <= pptr_d;
      pact_q       <= pact_d;
      wcnt_q       <= wcnt_d;
      end_seen_q   <= end_seen_d;
      people_q     <= people_d;
      ready_fifo_q <= ready_fifo_d;
      thing_q      <= thing_d;
      num_q        <= num_d;
      ready_lifo_q <= ready_lifo_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
      load_ovf_q   <= load_ovf_d;
      timeout_q    <= timeout_d;
    end
  end

  assign people_thing_in = people_q;
  assign ready_fifo      = ready_fifo_q;
  assign thing_in        = thing_q;
  assign thing_num       = num_q;
  assign ready_lifo      = ready_lifo_q;
  assign busy            = busy_q;
  assign tx_done         = tx_done_q;
  assign load_ovf        = load_ovf_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_cipu_stream_tx.sv
// Bench for cipu_stream_tx: directed scenarios plus randomized scripts checked
// cycle by cycle against a schedule model derived from the protocol rules.
module tb_cipu_stream_tx;
  import cipu_pkg::*;

  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 64;
  localparam int NMAX    = 1024;

  logic       clk = 1'b0;
  logic       rst, load_en, load_sel, start, done_thing, done_lifo;
  logic [7:0] load_char;
  logic [3:0] load_num;
  logic [7:0] people_thing_in, thing_in;
  logic [3:0] thing_num;
  logic       ready_fifo, ready_lifo, busy, tx_done, load_ovf, timeout_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] pax_q[$];
  logic [7:0] bag_ch_q[$];
  logic [3:0] bag_num_q[$];
  int         pop_d_q[$];

  cipu_stream_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_en         (load_en),
    .load_sel        (load_sel),
    .load_char       (load_char),
    .load_num        (load_num),
    .start           (start),
    .done_thing      (done_thing),
    .done_lifo       (done_lifo),
    .people_thing_in (people_thing_in),
    .ready_fifo      (ready_fifo),
    .thing_in        (thing_in),
    .thing_num       (thing_num),
    .ready_lifo      (ready_lifo),
    .busy            (busy),
    .tx_done         (tx_done),
    .load_ovf        (load_ovf),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_char = 8'h00; load_num = 4'h0;
    start = 1'b0; done_thing = 1'b0; done_lifo = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_entry(input logic sel, input logic [7:0] ch, input logic [3:0] num);
    load_en = 1'b1; load_sel = sel; load_char = ch; load_num = num;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic load_scripts;
    foreach (pax_q[i]) load_entry(1'b0, pax_q[i], 4'h0);
    foreach (bag_ch_q[i]) load_entry(1'b1, bag_ch_q[i], bag_num_q[i]);
  endtask

  // Model: each baggage entry occupies one cycle; a ';' adds its consumer delay,
  // '$' (explicit or supplied) ends the baggage stream. Passengers occupy cycles
  // 1..P. DONE is entered at max(done_lifo edge, P+1); tx_done shows one cycle later.
  task automatic run_playback(input int e, input string tag);
    bit [7:0]   ech [NMAX];
    bit [3:0]   enm [NMAX];
    bit         erl [NMAX];
    bit         dt  [NMAX];
    bit         dl  [NMAX];
    logic [7:0] bch[$];
    logic [3:0] bnum[$];
    logic [7:0] exp_pi;
    bit         has_dollar;
    int         c, endc, dedge, p, pi;
    bch = bag_ch_q; bnum = bag_num_q;
    has_dollar = 1'b0;
    foreach (bch[i]) if (bch[i] == CH_DOLLAR) has_dollar = 1'b1;
    if (!has_dollar) begin bch.push_back(CH_DOLLAR); bnum.push_back(4'h0); end
    c = 1; pi = 0; endc = 0;
    for (int i = 0; i < bch.size(); i++) begin
      erl[c] = 1'b1; ech[c] = bch[i];
      enm[c] = (bch[i] == CH_SEMI) ? bnum[i] : 4'h0;
      if (bch[i] == CH_SEMI) begin
        dt[c + pop_d_q[pi] - 1] = 1'b1;
        c = c + pop_d_q[pi] + 1;
        pi++;
      end else if (bch[i] == CH_DOLLAR) begin
        endc = c;
        break;
      end else begin
        c++;
      end
    end
    dl[endc + e - 1] = 1'b1;
    p = pax_q.size();
    dedge = (endc + e > p + 1) ? endc + e : p + 1;

    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= dedge + 2; n++) begin
      @(posedge clk);
      #1;
      exp_pi = (n <= p) ? pax_q[n-1] : 8'h00;
      checks++;
      if (ready_fifo !== (n <= p)) begin
        errors++; $display("FAIL %s ready_fifo cyc=%0d got=%0b exp=%0b", tag, n, ready_fifo, (n <= p));
      end
      checks++;
      if (people_thing_in !== exp_pi) begin
        errors++; $display("FAIL %s people_thing_in cyc=%0d got=%h exp=%h", tag, n, people_thing_in, exp_pi);
      end
      checks++;
      if (ready_lifo !== erl[n]) begin
        errors++; $display("FAIL %s ready_lifo cyc=%0d got=%0b exp=%0b", tag, n, ready_lifo, erl[n]);
      end
      if (erl[n]) begin
        checks++;
        if (thing_in !== ech[n]) begin
          errors++; $display("FAIL %s thing_in cyc=%0d got=%h exp=%h", tag, n, thing_in, ech[n]);
        end
      end
      checks++;
      if (thing_num !== enm[n]) begin
        errors++; $display("FAIL %s thing_num cyc=%0d got=%0d exp=%0d", tag, n, thing_num, enm[n]);
      end
      checks++;
      if (busy !== (n <= dedge)) begin
        errors++; $display("FAIL %s busy cyc=%0d got=%0b exp=%0b", tag, n, busy, (n <= dedge));
      end
      checks++;
      if (tx_done !== (n > dedge)) begin
        errors++; $display("FAIL %s tx_done cyc=%0d got=%0b exp=%0b", tag, n, tx_done, (n > dedge));
      end
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++; $display("FAIL %s timeout_err cyc=%0d got=%0b exp=0", tag, n, timeout_err);
      end
      done_thing = dt[n];
      done_lifo  = dl[n];
    end
    done_thing = 1'b0;
    done_lifo  = 1'b0;
  endtask

  task automatic test_reset;
    logic [35:0] got;
    do_reset();
    got = {people_thing_in, ready_fifo, thing_in, thing_num, ready_lifo, busy, tx_done,
           load_ovf, timeout_err, 5'd0};
    checks++;
    if (got !== 36'h0) begin
      errors++; $display("FAIL reset outputs got=%h exp=0", got);
    end
  endtask

  task automatic test_basic;
    do_reset();
    pax_q = '{8'h41, 8'h42, 8'h43};
    bag_ch_q = '{8'h78, 8'h79, CH_DOLLAR}; bag_num_q = '{4'h0, 4'h0, 4'h0};
    pop_d_q.delete();
    load_scripts();
    run_playback(1, "basic");
  endtask

  task automatic test_pop;
    do_reset();
    pax_q = '{8'h4B, 8'h4C};
    bag_ch_q = '{8'h61, 8'h62, CH_SEMI, 8'h63, CH_DOLLAR};
    bag_num_q = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    pop_d_q = '{4};
    load_scripts();
    run_playback(2, "pop");
  endtask

  task automatic test_zero_count;
    do_reset();
    pax_q.delete();
    bag_ch_q = '{CH_SEMI, CH_DOLLAR}; bag_num_q = '{4'h0, 4'h0};
    pop_d_q = '{3};
    load_scripts();
    run_playback(1, "zero_count");
  endtask

  task automatic test_auto_dollar;
    do_reset();
    pax_q = '{8'h5A};
    bag_ch_q = '{8'h61, 8'h62, 8'h63}; bag_num_q = '{4'h5, 4'h6, 4'h7};
    pop_d_q.delete();
    load_scripts();
    run_playback(3, "auto_dollar");
  endtask

  task automatic test_overflow;
    logic [7:0] ch;
    do_reset();
    pax_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      ch = 8'(8'h41 + $urandom_range(0, 25));
      pax_q.push_back(ch);
      load_entry(1'b0, ch, 4'h0);
      if (i == DEPTH - 1) begin
        checks++;
        if (load_ovf !== 1'b0) begin
          errors++; $display("FAIL overflow load_ovf_at_full got=%0b exp=0", load_ovf);
        end
      end
    end
    checks++;
    if (load_ovf !== 1'b1) begin
      errors++; $display("FAIL overflow load_ovf_after_extra got=%0b exp=1", load_ovf);
    end
    void'(pax_q.pop_back());
    bag_ch_q = '{8'h6B, CH_DOLLAR}; bag_num_q = '{4'h0, 4'h0};
    pop_d_q.delete();
    foreach (bag_ch_q[i]) load_entry(1'b1, bag_ch_q[i], bag_num_q[i]);
    run_playback(2, "overflow");
    checks++;
    if (load_ovf !== 1'b1) begin
      errors++; $display("FAIL overflow load_ovf_sticky got=%0b exp=1", load_ovf);
    end
  endtask

  task automatic test_timeout_and_reset;
    logic [35:0] got;
    do_reset();
    pax_q = '{8'h50, 8'h51};
    bag_ch_q = '{8'h61, CH_SEMI}; bag_num_q = '{4'h0, 4'h3};
    load_scripts();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= TIMEOUT + 3; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) begin
        checks++;
        if ({ready_lifo, thing_in, thing_num} !== {1'b1, CH_SEMI, 4'h3}) begin
          errors++; $display("FAIL timeout semi_cycle got=%b/%h/%0d exp=1/3b/3", ready_lifo, thing_in, thing_num);
        end
      end
      if (n == TIMEOUT + 1) begin
        checks++;
        if ({timeout_err, ready_lifo} !== 2'b00) begin
          errors++; $display("FAIL timeout early got=%b exp=00", {timeout_err, ready_lifo});
        end
      end
      if (n == TIMEOUT + 2) begin
        checks++;
        if (timeout_err !== 1'b1) begin
          errors++; $display("FAIL timeout flag got=%0b exp=1", timeout_err);
        end
      end
      if (n == TIMEOUT + 3) begin
        checks++;
        if ({tx_done, busy, timeout_err} !== 3'b101) begin
          errors++; $display("FAIL timeout done_state got=%b exp=101", {tx_done, busy, timeout_err});
        end
      end
    end
    // Replay from DONE, then reset in the middle of it.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ready_lifo, thing_in, ready_fifo, people_thing_in} !== {1'b1, 8'h61, 1'b1, 8'h50}) begin
      errors++; $display("FAIL replay first_cycle got=%b/%h/%b/%h exp=1/61/1/50", ready_lifo, thing_in, ready_fifo, people_thing_in);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    got = {people_thing_in, ready_fifo, thing_in, thing_num, ready_lifo, busy, tx_done,
           load_ovf, timeout_err, 5'd0};
    checks++;
    if (got !== 36'h0) begin
      errors++; $display("FAIL midreset outputs got=%h exp=0", got);
    end
  endtask

  task automatic test_random;
    int np, nb;
    for (int it = 0; it < 10; it++) begin
      pax_q.delete(); bag_ch_q.delete(); bag_num_q.delete(); pop_d_q.delete();
      np = $urandom_range(0, DEPTH);
      for (int i = 0; i < np; i++) pax_q.push_back(8'(8'h41 + $urandom_range(0, 25)));
      nb = $urandom_range(0, 20);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bag_ch_q.push_back(CH_SEMI);
          pop_d_q.push_back($urandom_range(1, 10));
        end else begin
          bag_ch_q.push_back(8'(8'h61 + $urandom_range(0, 25)));
        end
        bag_num_q.push_back(4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 1) == 1) begin
        bag_ch_q.push_back(CH_DOLLAR);
        bag_num_q.push_back(4'($urandom_range(0, 15)));
      end
      do_reset();
      load_scripts();
      run_playback($urandom_range(1, 10), "random");
    end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_char = 8'h00; load_num = 4'h0;
    start = 1'b0; done_thing = 1'b0; done_lifo = 1'b0;
    test_reset();
    test_basic();
    test_pop();
    test_zero_count();
    test_auto_dollar();
    test_overflow();
    test_timeout_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cipu_stream_tx.md
# cipu_stream_tx

Transmitter for the CIPU check-in stream protocol: stores a passenger script and a baggage script, then plays both into the CIPU input ports. Passengers are sent one character per cycle. Baggage characters, `;` pop commands with a count and the `$` terminator are paced by `done_thing` and `done_lifo` handshakes. Sits upstream of CIPU in the check-in datapath and also serves as the bench stimulus source.

## Interface
- `DEPTH`, 32: entries per script memory (power of two).
- `TIMEOUT`, 64: max cycles to wait for `done_thing` or `done_lifo` before flagging an error.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_en`  in  1  write one script entry (accepted in IDLE only).
- `load_sel`  in  1  0 = passenger script, 1 = baggage script.
- `load_char`  in  8  ASCII character to store.
- `load_num`  in  4  pop count stored with a baggage `;` entry (ignored otherwise).
- `start`  in  1  begin playback.
- `done_thing`  in  1  CIPU finished a pop group.
- `done_lifo`  in  1  CIPU accepted `$`.
- `people_thing_in`  out  8  passenger character to CIPU.
- `ready_fifo`  out  1  qualifies `people_thing_in`.
- `thing_in`  out  8  baggage character to CIPU.
- `thing_num`  out  4  pop count; meaningful only with `;`.
- `ready_lifo`  out  1  qualifies `thing_in` / `thing_num`.
- `busy`  out  1  playback in progress.
- `tx_done`  out  1  playback complete (level).
- `load_ovf`  out  1  sticky: a write hit a full script.
- `timeout_err`  out  1  sticky: handshake wait exceeded `TIMEOUT`.

## Operation
- Reset: every output is 0, the FSM is in IDLE, and both write pointers are 0. Memory contents are don't-care.
- Loading happens in IDLE. `load_en` writes `{load_char, load_num}` to the selected script at its write pointer, then the pointer increments.
- A write to a full script (pointer == `DEPTH`) is dropped and sets `load_ovf`.
- FSM states and transitions:
  - IDLE → SEND on `start`.
  - SEND: drives the next baggage entry.
    - Ordinary character: next entry on the following cycle.
    - `;`: → WAIT_POP.
    - `$`, or baggage script exhausted: → WAIT_END. If the script ended without `$`, the block sends an auto-appended `$` first.
  - WAIT_POP: `ready_lifo` = 0. Sampling `done_thing` = 1 → SEND.
  - WAIT_END: `ready_lifo` = 0. Sampling `done_lifo` = 1, with the passenger stream exhausted → DONE.
  - DONE: `tx_done` = 1 and `busy` = 0. `start` replays both scripts: read pointers are cleared and the FSM goes → SEND. `load_en` is ignored in DONE.
- Passenger stream runs independently of the baggage FSM:
  - From the cycle after `start`, one entry per cycle with `ready_fifo` = 1.
  - Never stalled by WAIT_POP.
  - After the last entry, `ready_fifo` = 0 and `people_thing_in` = 8'h00.
- `thing_num` carries the stored count only on the `;` cycle and is 0 otherwise. A count of 0 is legal: CIPU emits `"0"` and still asserts `done_thing`.
- Wait counter:
  - Resets on entry to WAIT_POP or WAIT_END.
  - Reaching `TIMEOUT` sets `timeout_err` and forces → DONE.
- `start` outside IDLE or DONE is ignored.
- `rst` mid-playback returns to IDLE and clears pointers and flags on the next edge. Script contents are not guaranteed to survive reset.
- Widths: pointers are `$clog2(DEPTH)+1` bits, the wait counter is `$clog2(TIMEOUT)+1` bits, and all compares are unsigned.

## Timing
- All outputs are registered.
- `start` sampled at edge t → first characters valid on both streams after edge t+1.
- Consecutive ordinary baggage characters go out at 1 per cycle.
- A `;` is held for exactly one cycle with `ready_lifo` = 1.
- `done_thing` sampled at edge u → next baggage entry valid after edge u+1.
- `done_thing` during SEND is ignored. Consumer must not assert it then.
- `done_lifo` sampled high at edge w (passengers exhausted) → `tx_done` high after edge w+1.
- If passengers are still streaming at that point, DONE waits for the last passenger cycle. `done_lifo` is latched, not re-required.
- `done_thing` and the timeout expiring on the same edge: the handshake wins and there is no error.

## Structure
- Package `cipu_pkg`:
  - Character constants `CH_SEMI` = 8'h3B, `CH_DOLLAR` = 8'h24, `CH_ZERO` = 8'h30, `CH_A` = 8'h41, `CH_Z` = 8'h5A.
  - FSM state enum (IDLE, SEND, WAIT_POP, WAIT_END, DONE).
  - Script-entry struct {char[7:0], num[3:0]}.
- Sub-module `cipu_script_mem`: DEPTH×12 storage, synchronous write, combinational read, write pointer and full flag. Instantiated twice.

## Test plan
- Passengers "ABC", baggage "xy$" → `people_thing_in` = A,B,C on cycles 1–3, then `ready_fifo` = 0. `thing_in` = x,y,$ on cycles 1–3. `tx_done` = 1 one cycle after `done_lifo`.
- Baggage "ab;" with num = 2, then "c$". `done_thing` asserted 4 cycles after the `;` → `ready_lifo` = 0 for 4 cycles, then `c` on the cycle after `done_thing`.
- Baggage ";" with num = 0, then "$" → `thing_num` = 0 on the `;` cycle, stall until `done_thing`, then `$`.
- Baggage script of "abc" with no `$` → an auto `$` is driven on cycle 4.
- 33 passenger writes with `DEPTH` = 32 → `load_ovf` = 1, and only 32 characters are played.
- `done_thing` withheld → `timeout_err` = 1 exactly `TIMEOUT` cycles after the `;`, FSM in DONE. Then `rst` mid-playback → all outputs 0 on the next cycle.
